// File: rtl/mem_port_server_pkg.sv
// Shared types and defaults for the accelerator memory port server.
// Read/write FSM state encodings and the 64-bit ready pulse value.
package mem_port_server_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_PULSE, R_HOLD} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_PULSE, W_HOLD} wr_state_t;

  localparam logic [63:0] READY_ONE = 64'd1;

  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_ADDR_SHIFT = 2;

endpackage

// File: rtl/mps_word_ram.sv
// Dual-port 32-bit synchronous RAM: port a reads (accelerator or host), port b writes.
// Port a has two output registers so the host view holds while the accelerator read loads.
module mps_word_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] a_addr,
  input  logic                  a_rd_sel,
  output logic [31:0]           a_rd_q,
  output logic [31:0]           a_host_q,
  input  logic                  b_we,
  input  logic [DEPTH_LOG2-1:0] b_addr,
  input  logic [31:0]           b_wdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Array is never reset; only the output registers are.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_q   <= '0;
      a_host_q <= '0;
    end else if (a_rd_sel) begin
      a_rd_q   <= mem[a_addr];
    end else begin
      a_host_q <= mem[a_addr];
    end
  end

endmodule

// File: rtl/mem_port_server.sv
// Serves accelerator read/write sessions against a word RAM with a fixed response latency.
// Host preload port is only honoured while both session FSMs are idle.
module mem_port_server
  import mem_port_server_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int ADDR_SHIFT = DEF_ADDR_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_enable,
  input  logic [63:0]           read_addr,
  input  logic                  finish_read,
  output logic [63:0]           read_ready,
  output logic [31:0]           read_data,
  input  logic                  write_enable,
  input  logic [63:0]           write_addr,
  input  logic [31:0]           write_data,
  input  logic                  finish_write,
  output logic [63:0]           write_ready,
  input  logic                  host_we,
  input  logic [DEPTH_LOG2-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic                  addr_err,
  output logic                  proto_err
);

  localparam int HI = ADDR_SHIFT + DEPTH_LOG2;
  // Cycles spent in WAIT after acceptance, minus one (the last WAIT cycle issues the RAM op).
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  function automatic idx_t word_idx(input logic [63:0] a);
    return a[ADDR_SHIFT +: DEPTH_LOG2];
  endfunction

  function automatic logic out_of_range(input logic [63:0] a);
    return (a >> HI) != 64'd0;
  endfunction

  rd_state_t   rd_st;
  wr_state_t   wr_st;
  logic [3:0]  rd_wait, wr_wait;
  idx_t        rd_idx, wr_idx;
  logic [31:0] wr_dat;
  logic        rd_pulse, wr_pulse;

  logic rd_accept, wr_accept, rd_load, wr_commit, host_ok;
  idx_t rd_idx_now, wr_idx_now;
  logic [31:0] wr_data_now;

  assign rd_accept = read_enable && (rd_st == R_IDLE || (rd_st == R_HOLD && finish_read));
  assign wr_accept = write_enable && (wr_st == W_IDLE || (wr_st == W_HOLD && finish_write));

  // RAM op happens on the edge that enters PULSE; with LATENCY=1 that is the acceptance edge.
  assign rd_load   = read_enable && ((rd_st == R_WAIT && rd_wait == 4'd0) || (LATENCY == 1 && rd_accept));
  assign wr_commit = write_enable && ((wr_st == W_WAIT && wr_wait == 4'd0) || (LATENCY == 1 && wr_accept));

  assign rd_idx_now  = (rd_st == R_WAIT) ? rd_idx : word_idx(read_addr);
  assign wr_idx_now  = (wr_st == W_WAIT) ? wr_idx : word_idx(write_addr);
  assign wr_data_now = (wr_st == W_WAIT) ? wr_dat : write_data;

  assign host_ok = host_we && rd_st == R_IDLE && wr_st == W_IDLE && !wr_commit;

  mps_word_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk      (clk),
    .reset    (reset),
    .a_addr   (rd_load ? rd_idx_now : host_addr),
    .a_rd_sel (rd_load),
    .a_rd_q   (read_data),
    .a_host_q (host_rdata),
    .b_we     ((wr_commit || host_ok) && !reset),
    .b_addr   (wr_commit ? wr_idx_now : host_addr),
    .b_wdata  (wr_commit ? wr_data_now : host_wdata)
  );

  assign read_ready  = rd_pulse ? READY_ONE : 64'd0;
  assign write_ready = wr_pulse ? READY_ONE : 64'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_st    <= R_IDLE;
      rd_wait  <= '0;
      rd_idx   <= '0;
      rd_pulse <= 1'b0;
      rd_count <= '0;
    end else begin
      rd_pulse <= 1'b0;
      if (!read_enable) begin
        rd_st <= R_IDLE;
      end else if (rd_accept) begin
        rd_idx  <= word_idx(read_addr);
        rd_wait <= WAIT_INIT;
        if (LATENCY == 1) begin
          rd_st    <= R_PULSE;
          rd_pulse <= 1'b1;
          rd_count <= rd_count + 32'd1;
        end else begin
          rd_st <= R_WAIT;
        end
      end else begin
        case (rd_st)
          R_WAIT: begin
            if (rd_wait == 4'd0) begin
              rd_st    <= R_PULSE;
              rd_pulse <= 1'b1;
              rd_count <= rd_count + 32'd1;
            end else begin
              rd_wait <= rd_wait - 4'd1;
            end
          end
          R_PULSE: rd_st <= R_HOLD;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_st    <= W_IDLE;
      wr_wait  <= '0;
      wr_idx   <= '0;
      wr_dat   <= '0;
      wr_pulse <= 1'b0;
      wr_count <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (!write_enable) begin
        wr_st <= W_IDLE;
      end else if (wr_accept) begin
        wr_idx  <= word_idx(write_addr);
        wr_dat  <= write_data;
        wr_wait <= WAIT_INIT;
        if (LATENCY == 1) begin
          wr_st    <= W_PULSE;
          wr_pulse <= 1'b1;
          wr_count <= wr_count + 32'd1;
        end else begin
          wr_st <= W_WAIT;
        end
      end else begin
        case (wr_st)
          W_WAIT: begin
            if (wr_wait == 4'd0) begin
              wr_st    <= W_PULSE;
              wr_pulse <= 1'b1;
              wr_count <= wr_count + 32'd1;
            end else begin
              wr_wait <= wr_wait - 4'd1;
            end
          end
          W_PULSE: wr_st <= W_HOLD;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if ((rd_accept && out_of_range(read_addr)) || (wr_accept && out_of_range(write_addr)))
        addr_err <= 1'b1;
      if ((finish_read && rd_st != R_HOLD) || (finish_write && wr_st != W_HOLD) ||
          (host_we && !host_ok))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_server.sv
// Scoreboarded bench for mem_port_server: drivers push expected responses, a monitor checks pulses.
module tb_mem_port_server;

  localparam int LAT = 2;

  logic        clk, reset;
  logic        read_enable, finish_read, write_enable, finish_write, host_we;
  logic [63:0] read_addr, write_addr, read_ready, write_ready;
  logic [31:0] write_data, read_data, host_wdata, host_rdata, rd_count, wr_count;
  logic [9:0]  host_addr;
  logic        addr_err, proto_err;

  mem_port_server dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
    .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .finish_write(finish_write), .write_ready(write_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .rd_count(rd_count), .wr_count(wr_count), .addr_err(addr_err), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
  rd_exp_t     rd_q[$];
  int          wr_q[$];
  logic [31:0] mem_m [1024];
  int          checks = 0, failures = 0;
  int          exp_rd = 0, exp_wr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 2) & 64'd1023);
  endfunction

  // Expected response: the model word at the truncated index, LAT cycles after the request.
  task automatic push_rd(input logic [63:0] a);
    rd_exp_t e;
    e.data = mem_m[idx_of(a)];
    e.cyc  = cyc + LAT;
    rd_q.push_back(e);
    exp_rd++;
  endtask

  task automatic push_wr(input logic [63:0] a, input logic [31:0] d);
    wr_q.push_back(cyc + LAT);
    mem_m[idx_of(a)] = d;
    exp_wr++;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (read_ready != 64'd0) begin
        chk("rd_ready_val", read_ready, 64'd1);
        if (rd_q.size() == 0) chk("rd_unexpected_pulse", 64'd1, 64'd0);
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rd_data", {32'd0, read_data}, {32'd0, e.data});
          chk("rd_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (write_ready != 64'd0) begin
        chk("wr_ready_val", write_ready, 64'd1);
        if (wr_q.size() == 0) chk("wr_unexpected_pulse", 64'd1, 64'd0);
        else chk("wr_latency", 64'(cyc), 64'(wr_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd();
    int n = 0;
    do begin @(negedge clk); n++; end while (!read_ready[0] && n < 40);
    if (!read_ready[0]) chk("rd_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_wr();
    int n = 0;
    do begin @(negedge clk); n++; end while (!write_ready[0] && n < 40);
    if (!write_ready[0]) chk("wr_timeout", 64'd0, 64'd1);
  endtask

  task automatic read_session(input logic [63:0] base, input logic [63:0] stride, input int n);
    logic [63:0] a;
    a = base;
    tick();
    read_enable = 1'b1; read_addr = a; push_rd(a);
    for (int i = 0; i < n; i++) begin
      wait_rd();
      tick();
      if (i < n - 1) begin
        a += stride;
        read_addr = a; finish_read = 1'b1; push_rd(a);
        tick();
        finish_read = 1'b0;
      end
    end
    read_enable = 1'b0;
  endtask

  task automatic write_session(input logic [63:0] base, input logic [63:0] stride, input int n,
                               input logic [31:0] d [4]);
    logic [63:0] a;
    a = base;
    tick();
    write_enable = 1'b1; write_addr = a; write_data = d[0]; push_wr(a, d[0]);
    for (int i = 0; i < n; i++) begin
      wait_wr();
      tick();
      if (i < n - 1) begin
        a += stride;
        write_addr = a; write_data = d[i+1]; finish_write = 1'b1; push_wr(a, d[i+1]);
        tick();
        finish_write = 1'b0;
      end
    end
    write_enable = 1'b0;
  endtask

  task automatic host_write(input int i, input logic [31:0] v);
    tick();
    host_we = 1'b1; host_addr = 10'(i); host_wdata = v;
    tick();
    host_we = 1'b0;
    mem_m[i] = v;
  endtask

  task automatic host_check(input string name, input int i);
    tick();
    host_addr = 10'(i);
    tick();
    chk(name, {32'd0, host_rdata}, {32'd0, mem_m[i]});
  endtask

  initial begin
    logic [31:0] d [4];
    reset = 1'b1;
    read_enable = 0; finish_read = 0; read_addr = '0;
    write_enable = 0; finish_write = 0; write_addr = '0; write_data = '0;
    host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    chk("rst_read_ready", read_ready, 64'd0);
    chk("rst_write_ready", write_ready, 64'd0);
    chk("rst_read_data", {32'd0, read_data}, 64'd0);
    chk("rst_host_rdata", {32'd0, host_rdata}, 64'd0);
    chk("rst_rd_count", {32'd0, rd_count}, 64'd0);
    chk("rst_wr_count", {32'd0, wr_count}, 64'd0);
    chk("rst_addr_err", {63'd0, addr_err}, 64'd0);
    chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
    reset = 1'b0;

    // Preload: the four documented words, then random data for the rest of the working range.
    host_write(0, 32'd5); host_write(1, 32'd3); host_write(2, 32'd9); host_write(3, 32'd1);
    for (int i = 4; i < 256; i++) host_write(i, $urandom);
    for (int i = 0; i < 4; i++) host_check("host_preload", i);

    read_session(64'h0, 64'd4, 4);
    repeat (3) tick();
    chk("rd_count_4", {32'd0, rd_count}, 64'(exp_rd));

    d = '{32'd1, 32'd3, 32'd5, 32'd9};
    write_session(64'h100, 64'd4, 4, d);
    repeat (3) tick();
    for (int i = 64; i < 68; i++) host_check("host_after_write", i);
    chk("wr_count_4", {32'd0, wr_count}, 64'(exp_wr));

    for (int k = 0; k < 10; k++) begin
      logic [63:0] base, stride;
      int n;
      base   = 64'($urandom_range(0, 200)) << 2;
      stride = 64'($urandom_range(1, 3)) << 2;
      n      = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) read_session(base, stride, n);
      else begin
        for (int j = 0; j < 4; j++) d[j] = $urandom;
        write_session(base, stride, n, d);
      end
    end
    repeat (3) tick();
    chk("rand_rd_count", {32'd0, rd_count}, 64'(exp_rd));
    chk("rand_wr_count", {32'd0, wr_count}, 64'(exp_wr));

    // Abandon a read while it waits; then an immediate fresh read proves the FSM is idle.
    tick(); read_enable = 1'b1; read_addr = 64'h0;
    tick(); read_enable = 1'b0;
    repeat (4) tick();
    chk("drop_rd_count", {32'd0, rd_count}, 64'(exp_rd));
    read_session(64'h8, 64'd4, 1);

    chk("proto_before", {63'd0, proto_err}, 64'd0);
    tick(); read_enable = 1'b1; read_addr = 64'hC; push_rd(64'hC);
    tick(); finish_read = 1'b1;
    tick(); finish_read = 1'b0;
    repeat (5) tick();
    read_enable = 1'b0;
    tick();
    chk("proto_after", {63'd0, proto_err}, 64'd1);
    chk("proto_rd_count", {32'd0, rd_count}, 64'(exp_rd));

    // Same-cycle read and write to one word: read sees the old value, a later read the new.
    tick();
    read_enable = 1'b1; read_addr = 64'h200; push_rd(64'h200);
    write_enable = 1'b1; write_addr = 64'h200; write_data = 32'hA5A5_1234;
    push_wr(64'h200, 32'hA5A5_1234);
    wait_rd();
    tick(); read_enable = 1'b0; write_enable = 1'b0;
    read_session(64'h200, 64'd4, 1);

    chk("aerr_before", {63'd0, addr_err}, 64'd0);
    read_session(64'h1000, 64'd4, 1);
    tick();
    chk("aerr_after", {63'd0, addr_err}, 64'd1);

    // Reset while a write is still waiting: nothing may be committed.
    tick(); write_enable = 1'b1; write_addr = 64'h40; write_data = 32'hDEAD_BEEF;
    tick(); #2; reset = 1'b1; #1;
    chk("rst_mid_write_ready", write_ready, 64'd0);
    chk("rst_mid_wr_count", {32'd0, wr_count}, 64'd0);
    chk("rst_mid_rd_count", {32'd0, rd_count}, 64'd0);
    chk("rst_mid_aerr", {63'd0, addr_err}, 64'd0);
    chk("rst_mid_perr", {63'd0, proto_err}, 64'd0);
    write_enable = 1'b0;
    tick(); reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    host_check("rst_word_unchanged", 16);

    // Reset during a live read pulse clears it without waiting for a clock edge.
    tick(); read_enable = 1'b1; read_addr = 64'h8; push_rd(64'h8);
    wait_rd();
    #1; reset = 1'b1; #1;
    chk("rst_pulse_read_ready", read_ready, 64'd0);
    chk("rst_pulse_read_data", {32'd0, read_data}, 64'd0);
    read_enable = 1'b0;
    tick(); reset = 1'b0;
    exp_rd = 0;

    read_session(64'h0, 64'd4, 2);
    repeat (5) tick();
    chk("final_rd_count", {32'd0, rd_count}, 64'(exp_rd));
    chk("final_wr_count", {32'd0, wr_count}, 64'(exp_wr));
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
